// File: rtl/spi_rx_pkg.sv
// Shared types and default sizing for the SPI byte receiver.
package spi_rx_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_t;

    localparam int DATA_W_DEFAULT      = 8;
    localparam int SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/spi_sync.sv
// One multi-flop synchronizer chain with rise/fall detection on the synchronized output.
module spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] chain_q;
    logic              prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= {STAGES{RESET_VAL}};
            prev_q  <= RESET_VAL;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
            prev_q  <= chain_q[STAGES-1];
        end
    end

    assign q_o    = chain_q[STAGES-1];
    assign rise_o = chain_q[STAGES-1] & ~prev_q;
    assign fall_o = ~chain_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_byte_receiver.sv
// SPI slave word receiver with rx handshake, overrun and frame-error pulses.
// Optional MISO return path enabled by defining SPI_BYTE_RECEIVER_MISO_EN.
module spi_byte_receiver
    import spi_rx_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SCL,
    input  logic              MOSI,
    input  logic              SS,
    output logic              MISO,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [DATA_W-1:0] tx_data,
    output logic              overrun,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(DATA_W);
    // Bit order {SS, MOSI, SCL}; SS idles high so its chain resets to 1.
    localparam logic [2:0] SYNC_RST = 3'b100;

    logic [2:0] raw_in;
    logic [2:0] sync_lvl;
    logic [2:0] sync_rise;
    logic [2:0] sync_fall;

    assign raw_in = {SS, MOSI, SCL};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            spi_sync #(
                .STAGES    (SYNC_STAGES),
                .RESET_VAL (SYNC_RST[gi])
            ) u_sync (
                .clk    (clk),
                .rst    (rst),
                .d_i    (raw_in[gi]),
                .q_o    (sync_lvl[gi]),
                .rise_o (sync_rise[gi]),
                .fall_o (sync_fall[gi])
            );
        end
    endgenerate

    logic scl_rise;
    logic mosi_s;
    logic ss_s;
    assign scl_rise = sync_rise[0];
    assign mosi_s   = sync_lvl[1];
    assign ss_s     = sync_lvl[2];

    logic unused_edges;
    assign unused_edges = ^{sync_lvl[0], sync_rise[2:1], sync_fall[2:1]};

    spi_state_t        state_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_valid_q;
    logic              overrun_q;
    logic              frame_err_q;
    logic              last_bit;

    assign shift_d  = {shift_q[DATA_W-2:0], mosi_s};
    assign last_bit = (bit_cnt_q == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    bit_cnt_q <= '0;
                    if (!ss_s) begin
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ss_s) begin
                        state_q     <= IDLE;
                        bit_cnt_q   <= '0;
                        shift_q     <= '0;
                        frame_err_q <= (bit_cnt_q != '0);
                    end else if (scl_rise) begin
                        shift_q <= shift_d;
                        if (last_bit) begin
                            bit_cnt_q <= '0;
                            // A consume in this same cycle frees the slot for the new word.
                            if (rx_valid_q && !rx_ready) begin
                                overrun_q <= 1'b1;
                            end else begin
                                rx_data_q  <= shift_d;
                                rx_valid_q <= 1'b1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

`ifdef SPI_BYTE_RECEIVER_MISO_EN
    logic [DATA_W-1:0] tx_word_q;
    logic              miso_q;
    logic              scl_fall;
    assign scl_fall = sync_fall[0];

    // Bit index follows bit_cnt, so after a wrap (count 0) the MSB is re-driven.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_word_q <= '0;
            miso_q    <= 1'b0;
        end else if (state_q == IDLE) begin
            if (!ss_s) begin
                tx_word_q <= tx_data;
                miso_q    <= tx_data[DATA_W-1];
            end else begin
                miso_q <= 1'b0;
            end
        end else if (ss_s) begin
            miso_q <= 1'b0;
        end else if (scl_rise && last_bit) begin
            tx_word_q <= tx_data;
            miso_q    <= tx_data[DATA_W-1];
        end else if (scl_fall) begin
            miso_q <= tx_word_q[CNT_W'(DATA_W - 1) - bit_cnt_q];
        end
    end

    assign MISO = miso_q;
`else
    logic unused_tx;
    assign unused_tx = ^{tx_data, sync_fall[0]};
    assign MISO      = 1'b0;
`endif

endmodule
